// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC width, the NOP encoding and the fetch FSM states.
package cpu_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0] instr;
        logic [PC_W-1:0] next_pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with a combinational head and a flush that empties it.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory fetch, prefetch queue and Decode output register.
// Optional build macro FETCH_PERF_EN adds saturating FetchCount/FlushCount outputs.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Redirect,
    input  logic [PC_W-1:0] TruePC,
    output logic            IMemReq,
    output logic [PC_W-1:0] IMemAddr,
    input  logic            IMemGnt,
    input  logic            IMemValid,
    input  logic [PC_W-1:0] IMemData,
    output logic [PC_W-1:0] Instruct,
    output logic [PC_W-1:0] NextPC,
    output logic            InstrValid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     FetchCount,
    output logic [15:0]     FlushCount
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PC_W-1:0] instr_reg, next_pc_reg;
    logic            valid_reg;
    logic            granted, push, pop, fifo_push, full, empty;
    logic [CW-1:0]   count;
    fetch_entry_t    head, push_entry;

    // Only one request may be outstanding, so in REQ nothing is in flight and room means count < DEPTH.
    assign IMemReq   = (state_reg == REQ) && (count != CW'(DEPTH));
    assign IMemAddr  = fetch_pc_reg;
    assign granted   = IMemReq && IMemGnt;
    assign pop       = (!valid_reg || !Stall) && !empty && !Redirect;
    assign fifo_push = push && (!full || pop);

    // fetch_pc already points past the in-flight word, so it is that word's NextPC.
    assign push_entry.instr   = IMemData;
    assign push_entry.next_pc = fetch_pc_reg;

    fetch_fifo #(.DEPTH(DEPTH), .W(2 * PC_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (Redirect),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        push          = 1'b0;
        case (state_reg)
            IDLE:    state_next = REQ;
            REQ: begin
                if (granted) begin
                    fetch_pc_next = fetch_pc_reg + 16'd1;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (IMemValid) begin
                    push       = 1'b1;
                    state_next = REQ;
                end
            end
            DISCARD: if (IMemValid) state_next = REQ;
            default: state_next = IDLE;
        endcase
        // A response landing in the redirect cycle is dropped, which also retires the outstanding request.
        if (Redirect) begin
            push          = 1'b0;
            fetch_pc_next = TruePC;
            if (granted || (((state_reg == WAIT) || (state_reg == DISCARD)) && !IMemValid))
                state_next = DISCARD;
            else
                state_next = REQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg   <= 1'b0;
            instr_reg   <= NOP_INSTR;
            next_pc_reg <= RESET_PC + 16'd1;
        end else if (Redirect) begin
            valid_reg   <= 1'b0;
            instr_reg   <= NOP_INSTR;
            next_pc_reg <= TruePC;
        end else if (pop) begin
            valid_reg   <= 1'b1;
            instr_reg   <= head.instr;
            next_pc_reg <= head.next_pc;
        end else if (!Stall) begin
            valid_reg   <= 1'b0;
            instr_reg   <= NOP_INSTR;
        end
    end

    assign Instruct   = instr_reg;
    assign NextPC     = next_pc_reg;
    assign InstrValid = valid_reg;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_reg, flush_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (fifo_push && !Redirect && (fetch_count_reg != 16'hFFFF))
                fetch_count_reg <= fetch_count_reg + 16'd1;
            if (Redirect && (flush_count_reg != 16'hFFFF))
                flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    assign FetchCount = fetch_count_reg;
    assign FlushCount = flush_count_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory returns the address as data, so every accepted
// instruction must be {a, a+1} in the order queued by the stimulus.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst, Stall, Redirect, IMemGnt, IMemValid;
    logic [15:0] TruePC, IMemData, IMemAddr, Instruct, NextPC;
    logic        IMemReq, InstrValid;
`ifdef FETCH_PERF_EN
    logic [15:0] FetchCount, FlushCount;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .TruePC     (TruePC),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemGnt    (IMemGnt),
        .IMemValid  (IMemValid),
        .IMemData   (IMemData),
        .Instruct   (Instruct),
        .NextPC     (NextPC),
        .InstrValid (InstrValid)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (FetchCount),
        .FlushCount (FlushCount)
`endif
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          consumed = 0;
    int          mem_delay = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [15:0] start, input int n);
        logic [15:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, a + 16'd1});
            a = a + 16'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(IMemReq && IMemGnt) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no handshake within 50 cycles, got none, expected one", name);
        end
    endtask

    task automatic wait_consumed(input string name, input int target);
        int k;
        k = 0;
        while (consumed < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(consumed >= target), 32'd1);
    endtask

    // Memory model: handshake seen mid-cycle, response driven mem_delay cycles after the grant cycle.
    initial begin
        logic        hs, pend;
        logic [15:0] haddr, paddr;
        int          cnt;
        IMemValid = 1'b0;
        IMemData  = '0;
        pend      = 1'b0;
        paddr     = '0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            hs    = rst && IMemReq && IMemGnt;
            haddr = IMemAddr;
            @(posedge clk);
            #1;
            IMemValid = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend  = 1'b1;
                    paddr = haddr;
                    cnt   = mem_delay;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        IMemValid = 1'b1;
                        IMemData  = paddr;
                        pend      = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: an instruction is accepted in a cycle where it is valid and neither stalled nor flushed.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && InstrValid && !Stall && !Redirect) begin
                $display("txn Instruct=%h NextPC=%h", Instruct, NextPC);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL accept: got %h/%h, expected no instruction", Instruct, NextPC);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept", {Instruct, NextPC}, e);
                end
                consumed++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] held;
        int          k, c0;
        rst = 1'b0; Stall = 1'b0; Redirect = 1'b0; TruePC = '0; IMemGnt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(IMemReq),    32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", 32'(Instruct),   32'(NOP_INSTR));
        chk("rst_npc",   32'(NextPC),     32'h0000FFFF);

        // Reset release, wrap from FFFE through 0000
        expect_seq(RST_PC, 64);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("idle_noreq", 32'(IMemReq), 32'd0);
        @(negedge clk);
        chk("first_req",  32'(IMemReq),  32'd1);
        chk("first_addr", 32'(IMemAddr), 32'h0000FFFE);
        wait_consumed("run_wrap", 6);

        // Stall with the queue filling
        tick();
        Stall = 1'b1;
        k = 0;
        @(negedge clk);
        while (!InstrValid && k < 10) begin
            @(negedge clk);
            k++;
        end
        held = {Instruct, NextPC, InstrValid};
        chk("stall_valid", 32'(InstrValid), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("stall_hold", {Instruct, NextPC}, held[32:1]);
        end
        chk("full_noreq", 32'(IMemReq), 32'd0);
        tick();
        Stall = 1'b0;
        c0 = consumed;
        wait_consumed("stall_release", c0 + 10);

        // Redirect while a slow response is outstanding
        mem_delay = 3;
        wait_hs("hs_redir");
        tick();
        Redirect = 1'b1;
        TruePC = 16'h0040;
        exp_q.delete();
        expect_seq(16'h0040, 64);
        tick();
        Redirect = 1'b0;
        mem_delay = 0;
        @(negedge clk);
        chk("redir_valid",   32'(InstrValid), 32'd0);
        chk("discard_noreq", 32'(IMemReq),    32'd0);
        k = 0;
        while (!IMemReq && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("redir_addr", 32'(IMemAddr), 32'h00000040);
        c0 = consumed;
        wait_consumed("redir_run", c0 + 4);

        // Redirect together with Stall and a returning response
        wait_hs("hs_redir2");
        tick();
        Stall = 1'b1;
        Redirect = 1'b1;
        TruePC = 16'h0040;
        exp_q.delete();
        expect_seq(16'h0040, 64);
        tick();
        Redirect = 1'b0;
        @(negedge clk);
        chk("r2_valid", 32'(InstrValid), 32'd0);
        chk("r2_req",   32'(IMemReq),    32'd1);
        chk("r2_addr",  32'(IMemAddr),   32'h00000040);
        tick();
        Stall = 1'b0;
        c0 = consumed;
        wait_consumed("r2_run", c0 + 4);

        // Asynchronous reset mid-WAIT with a response pending
        mem_delay = 2;
        wait_hs("hs_rst");
        tick();
        #3;
        rst = 1'b0;
        Stall = 1'b1;
        #1;
        chk("arst_req",   32'(IMemReq),    32'd0);
        chk("arst_valid", 32'(InstrValid), 32'd0);
        chk("arst_instr", 32'(Instruct),   32'(NOP_INSTR));
        chk("arst_npc",   32'(NextPC),     32'h0000FFFF);
`ifdef FETCH_PERF_EN
        chk("arst_fcnt", 32'(FetchCount), 32'd0);
        chk("arst_xcnt", 32'(FlushCount), 32'd0);
`endif
        exp_q.delete();
        mem_delay = 0;
        tick();
        tick();
        expect_seq(RST_PC, 64);
        rst = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        chk("rst2_full_noreq", 32'(IMemReq), 32'd0);
        chk("rst2_head", {Instruct, NextPC}, 32'hFFFEFFFF);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", 32'(FetchCount), 32'd5);
`endif
        tick();
        Redirect = 1'b1;
        TruePC = 16'h0100;
        exp_q.delete();
        expect_seq(16'h0100, 64);
        tick();
        Redirect = 1'b0;
        @(negedge clk);
        chk("rst2_redir_valid", 32'(InstrValid), 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_flush",  32'(FlushCount), 32'd1);
        chk("perf_fetch2", 32'(FetchCount), 32'd5);
`endif
        tick();
        Stall = 1'b0;
        c0 = consumed;
        wait_consumed("final_run", c0 + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
